rob_gen: RTL and testbench

ROB_GEN -- requirements
Module: rob_gen

---
 rtl/rob_gen.sv | 198 +++++++++++++++++++
 tb/tb_rob_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_gen.sv
// rob_gen: reorder buffer with in-order commit, store memory handshake and branch flush
module rob_gen #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    alloc_valid,
  output logic                    alloc_ready,
  output logic [TAG_W-1:0]        alloc_tag,
  input  logic [1:0]              alloc_kind,
  input  logic [4:0]              alloc_dest,
  input  logic [1:0]              alloc_size,
  input  logic [DATA_W-1:0]       alloc_pc,
  input  logic                    alloc_pred,
  input  logic [TAG_W-1:0]        qa_tag,
  input  logic [TAG_W-1:0]        qb_tag,
  output logic                    qa_ready,
  output logic                    qb_ready,
  output logic [DATA_W-1:0]       qa_value,
  output logic [DATA_W-1:0]       qb_value,
  input  logic [TAG_W-1:0]        wb_tag,
  input  logic [DATA_W-1:0]       wb_value,
  input  logic [DATA_W-1:0]       wb_addr,
  input  logic [DATA_W-1:0]       wb_newpc,
  input  logic                    wb_taken,
  input  logic [DATA_W-1:0]       chk_addr,
  output logic                    chk_hit,
  output logic                    cm_valid,
  output logic [4:0]              cm_reg,
  output logic [TAG_W-1:0]        cm_tag,
  output logic [DATA_W-1:0]       cm_value,
  output logic                    st_req,
  output logic [DATA_W-1:0]       st_addr,
  output logic [DATA_W-1:0]       st_data,
  output logic [1:0]              st_size,
  input  logic                    st_ack,
  output logic                    bp_valid,
  output logic [DATA_W-1:0]       bp_pc,
  output logic                    bp_taken,
  output logic                    flush,
  output logic [DATA_W-1:0]       flush_pc,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] K_BR = 2'd1, K_ST = 2'd2, K_JALR = 2'd3;
  typedef enum logic [1:0] {IDLE, ST_WAIT, FLUSH} state_t;
  state_t state_q;
  logic [PW-1:0] head_q, tail_q, wb_idx, rel;
  logic [CW-1:0] count_q;
  logic [1:0] kind_q [DEPTH];
  logic [1:0] size_q [DEPTH];
  logic [4:0] dest_q [DEPTH];
  logic [DATA_W-1:0] pc_q [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];
  logic [DATA_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] newpc_q [DEPTH];
  logic pred_q [DEPTH];
  logic taken_q [DEPTH];
  logic ready_q [DEPTH];
  logic addr_valid_q [DEPTH];
  logic acc, ret, wb_en, head_rdy, mispred;
  logic [1:0] hk;
  assign count       = count_q;
  assign alloc_ready = (count_q != CW'(DEPTH)) && state_q != FLUSH;
  assign alloc_tag   = TAG_W'({1'b0, tail_q}) + TAG_W'(1);
  assign acc         = rdy && alloc_valid && alloc_ready;
  assign wb_en       = rdy && state_q != FLUSH && wb_tag != '0;
  assign wb_idx      = PW'(wb_tag - TAG_W'(1));
  assign hk          = kind_q[head_q];
  assign head_rdy    = count_q != '0 && ready_q[head_q];
  assign mispred     = (hk == K_BR && taken_q[head_q] != pred_q[head_q]) || hk == K_JALR;
  // a register-writing or branch head retires at the commit decision; a store retires on its ack
  assign ret = rdy && ((state_q == IDLE && head_rdy && hk != K_ST) || (state_q == ST_WAIT && st_ack));
  // operand lookup with same-cycle writeback bypass; tag 0 means the operand needs no producer
  assign qa_ready = qa_tag == '0 || wb_tag == qa_tag || ready_q[PW'(qa_tag - TAG_W'(1))];
  assign qb_ready = qb_tag == '0 || wb_tag == qb_tag || ready_q[PW'(qb_tag - TAG_W'(1))];
  assign qa_value = qa_tag == '0 ? '0 : wb_tag == qa_tag ? wb_value : value_q[PW'(qa_tag - TAG_W'(1))];
  assign qb_value = qb_tag == '0 ? '0 : wb_tag == qb_tag ? wb_value : value_q[PW'(qb_tag - TAG_W'(1))];
  // address conflict: only entries between head and head+count are live
  always_comb begin
    chk_hit = 1'b0;
    rel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PW'(i) - head_q;
      if (kind_q[i] == K_ST && addr_valid_q[i] && addr_q[i] == chk_addr && CW'(rel) < count_q) chk_hit = 1'b1;
    end
  end
  // entry storage: allocation fills the tail slot, writeback fills results, flush invalidates all
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        kind_q[i] <= '0;
        size_q[i] <= '0;
        dest_q[i] <= '0;
        pc_q[i] <= '0;
        value_q[i] <= '0;
        addr_q[i] <= '0;
        newpc_q[i] <= '0;
        pred_q[i] <= 1'b0;
        taken_q[i] <= 1'b0;
        ready_q[i] <= 1'b0;
        addr_valid_q[i] <= 1'b0;
      end
    end else if (rdy) begin
      if (state_q == FLUSH)
        for (int i = 0; i < DEPTH; i++) begin
          ready_q[i] <= 1'b0;
          addr_valid_q[i] <= 1'b0;
        end
      if (acc) begin
        kind_q[tail_q] <= alloc_kind;
        size_q[tail_q] <= alloc_size;
        dest_q[tail_q] <= alloc_dest;
        pc_q[tail_q] <= alloc_pc;
        pred_q[tail_q] <= alloc_pred;
        ready_q[tail_q] <= 1'b0;
        addr_valid_q[tail_q] <= 1'b0;
      end
      if (wb_en) begin
        value_q[wb_idx] <= wb_value;
        newpc_q[wb_idx] <= wb_newpc;
        taken_q[wb_idx] <= wb_taken;
        ready_q[wb_idx] <= 1'b1;
        if (kind_q[wb_idx] == K_ST) begin
          addr_q[wb_idx] <= wb_addr;
          addr_valid_q[wb_idx] <= 1'b1;
        end
      end
    end
  end
  // pointers, occupancy and the commit FSM with its registered pulse outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      cm_valid <= 1'b0;
      cm_reg <= '0;
      cm_tag <= '0;
      cm_value <= '0;
      st_req <= 1'b0;
      st_addr <= '0;
      st_data <= '0;
      st_size <= '0;
      bp_valid <= 1'b0;
      bp_pc <= '0;
      bp_taken <= 1'b0;
      flush <= 1'b0;
      flush_pc <= '0;
    end else if (rdy) begin
      cm_valid <= 1'b0;
      bp_valid <= 1'b0;
      flush <= 1'b0;
      if (acc) tail_q <= tail_q + PW'(1);
      if (ret) head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(acc) - CW'(ret);
      case (state_q)
        IDLE: if (head_rdy) begin
          if (hk == K_ST) begin
            st_req <= 1'b1;
            st_addr <= addr_q[head_q];
            st_data <= value_q[head_q];
            st_size <= size_q[head_q];
            state_q <= ST_WAIT;
          end else begin
            cm_valid <= hk != K_BR;
            cm_reg <= dest_q[head_q];
            cm_tag <= TAG_W'({1'b0, head_q}) + TAG_W'(1);
            cm_value <= value_q[head_q];
            bp_valid <= hk == K_BR;
            bp_pc <= pc_q[head_q];
            bp_taken <= taken_q[head_q];
            if (mispred) begin
              flush <= 1'b1;
              flush_pc <= (hk == K_JALR || taken_q[head_q]) ? newpc_q[head_q] : pc_q[head_q] + DATA_W'(4);
              state_q <= FLUSH;
            end
          end
        end
        ST_WAIT: if (st_ack) begin
          st_req <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          head_q <= '0;
          tail_q <= '0;
          count_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rob_gen.sv
// tb_rob_gen: directed scenarios for rob_gen with a queue scoreboard for commit-side outputs
module tb_rob_gen;
  localparam logic [1:0] K_ALU = 2'd0, K_BR = 2'd1, K_ST = 2'd2, K_JALR = 2'd3;
  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1;
  logic alloc_valid = 1'b0, alloc_ready, alloc_pred = 1'b0;
  logic [2:0] alloc_tag, qa_tag = '0, qb_tag = '0, wb_tag = '0, cm_tag, count;
  logic [1:0] alloc_kind = '0, alloc_size = '0, st_size;
  logic [4:0] alloc_dest = '0, cm_reg;
  logic [31:0] alloc_pc = '0, qa_value, qb_value, wb_value = '0, wb_addr = '0, wb_newpc = '0;
  logic [31:0] chk_addr = '0, cm_value, st_addr, st_data, bp_pc, flush_pc;
  logic qa_ready, qb_ready, wb_taken = 1'b0, chk_hit, cm_valid, st_req, st_ack = 1'b0;
  logic bp_valid, bp_taken, flush;
  typedef struct packed {logic [2:0] tag; logic [4:0] rd; logic [31:0] val;} cm_t;
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [1:0] s;} st_t;
  cm_t cm_q[$];
  st_t st_q[$];
  logic [32:0] bp_q[$];
  logic [31:0] fl_q[$];
  cm_t ce;
  st_t cur;
  logic [32:0] be;
  logic st_prev = 1'b0;
  int checks = 0, errors = 0, tl = 0;
  logic [2:0] t, t2;

  rob_gen #(.DEPTH(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_kind(alloc_kind), .alloc_dest(alloc_dest), .alloc_size(alloc_size),
    .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
    .qa_tag(qa_tag), .qb_tag(qb_tag), .qa_ready(qa_ready), .qb_ready(qb_ready),
    .qa_value(qa_value), .qb_value(qb_value),
    .wb_tag(wb_tag), .wb_value(wb_value), .wb_addr(wb_addr), .wb_newpc(wb_newpc), .wb_taken(wb_taken),
    .chk_addr(chk_addr), .chk_hit(chk_hit),
    .cm_valid(cm_valid), .cm_reg(cm_reg), .cm_tag(cm_tag), .cm_value(cm_value),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .st_ack(st_ack),
    .bp_valid(bp_valid), .bp_pc(bp_pc), .bp_taken(bp_taken),
    .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_alloc(input logic [1:0] k, input logic [4:0] d, input logic [1:0] sz,
                          input logic [31:0] pc, input logic pr, output logic [2:0] tag);
    alloc_valid = 1'b1; alloc_kind = k; alloc_dest = d; alloc_size = sz; alloc_pc = pc; alloc_pred = pr;
    #1;
    tag = 3'(tl + 1);
    chk("alloc_tag", 32'(alloc_tag), 32'(tag));
    chk("alloc_ready", 32'(alloc_ready), 1);
    @(negedge clk);
    alloc_valid = 1'b0;
    tl = (tl + 1) % 4;
  endtask

  task automatic do_wb(input logic [2:0] tg, input logic [31:0] v, input logic [31:0] a,
                       input logic [31:0] np, input logic tk);
    wb_tag = tg; wb_value = v; wb_addr = a; wb_newpc = np; wb_taken = tk; qa_tag = tg;
    #1;
    chk("qa_bypass_ready", 32'(qa_ready), 1);
    chk("qa_bypass_value", qa_value, v);
    @(negedge clk);
    wb_tag = '0;
  endtask

  // scoreboard monitor: every commit-side output event consumes the next expected entry
  always @(negedge clk) begin
    if (cm_valid) begin
      if (cm_q.size() == 0) chk("cm_unexpected", 32'(cm_valid), 0);
      else begin
        ce = cm_q.pop_front();
        chk("cm_tag", 32'(cm_tag), 32'(ce.tag));
        chk("cm_reg", 32'(cm_reg), 32'(ce.rd));
        chk("cm_value", cm_value, ce.val);
      end
    end
    if (bp_valid) begin
      if (bp_q.size() == 0) chk("bp_unexpected", 32'(bp_valid), 0);
      else begin
        be = bp_q.pop_front();
        chk("bp_pc", bp_pc, be[32:1]);
        chk("bp_taken", 32'(bp_taken), 32'(be[0]));
      end
    end
    if (flush) begin
      if (fl_q.size() == 0) chk("flush_unexpected", 32'(flush), 0);
      else chk("flush_pc", flush_pc, fl_q.pop_front());
    end
    if (st_req && !st_prev) begin
      if (st_q.size() == 0) chk("st_unexpected", 32'(st_req), 0);
      else cur = st_q.pop_front();
    end
    if (st_req) begin
      chk("st_addr", st_addr, cur.a);
      chk("st_data", st_data, cur.d);
      chk("st_size", 32'(st_size), 32'(cur.s));
    end
    st_prev = st_req;
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_alloc_ready", 32'(alloc_ready), 1);
    chk("rst_alloc_tag", 32'(alloc_tag), 1);
    chk("rst_pulses", {29'd0, cm_valid, st_req, flush}, 0);
    #1;
    chk("qb_tag0_ready", 32'(qb_ready), 1);
    chk("qb_tag0_value", qb_value, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    // fill to full, then commit in order
    for (int i = 0; i < 4; i++) do_alloc(K_ALU, 5'(i + 1), 2'd2, 32'(16 * i), 1'b0, t);
    chk("full_count", 32'(count), 4);
    chk("full_alloc_ready", 32'(alloc_ready), 0);
    qa_tag = 3'd1;
    #1;
    chk("qa_not_ready", 32'(qa_ready), 0);
    cm_q.push_back('{3'd1, 5'd1, 32'h55});
    do_wb(3'd1, 32'h55, 0, 0, 1'b0);
    @(negedge clk);
    chk("after_commit_alloc_ready", 32'(alloc_ready), 1);
    chk("after_commit_count", 32'(count), 3);
    for (int i = 2; i <= 4; i++) begin
      cm_q.push_back('{3'(i), 5'(i), 32'(32'h44 + 32'h11 * i)});
      do_wb(3'(i), 32'(32'h44 + 32'h11 * i), 0, 0, 1'b0);
    end
    repeat (3) @(negedge clk);
    chk("drain_count", 32'(count), 0);
    // wrap-around rounds
    for (int r = 0; r < 10; r++) begin
      do_alloc(K_ALU, 5'(r + 1), 2'd2, 32'(r), 1'b0, t);
      chk("wrap_tag", 32'(t), 32'((r % 4) + 1));
      cm_q.push_back('{t, 5'(r + 1), 32'(32'h100 + r)});
      do_wb(t, 32'(32'h100 + r), 0, 0, 1'b0);
    end
    repeat (2) @(negedge clk);
    chk("wrap_count", 32'(count), 0);
    // store with address conflict and delayed ack
    do_alloc(K_ST, 5'd0, 2'd2, 32'h40, 1'b0, t);
    chk_addr = 32'h1000;
    #1;
    chk("chk_hit_before_wb", 32'(chk_hit), 0);
    st_q.push_back('{32'h1000, 32'hDEADBEEF, 2'd2});
    do_wb(t, 32'hDEADBEEF, 32'h1000, 0, 1'b0);
    @(negedge clk);
    chk("st_req_up", 32'(st_req), 1);
    chk("chk_hit_store", 32'(chk_hit), 1);
    repeat (2) @(negedge clk);
    chk("st_req_held", 32'(st_req), 1);
    st_ack = 1'b1;
    @(negedge clk);
    st_ack = 1'b0;
    chk("st_req_down", 32'(st_req), 0);
    chk("st_retired_count", 32'(count), 0);
    chk("chk_hit_after", 32'(chk_hit), 0);
    // freeze while waiting for the store ack
    do_alloc(K_ST, 5'd0, 2'd1, 32'h50, 1'b0, t);
    st_q.push_back('{32'h2000, 32'h1234, 2'd1});
    do_wb(t, 32'h1234, 32'h2000, 0, 1'b0);
    @(negedge clk);
    rdy = 1'b0;
    st_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("freeze_st_req", 32'(st_req), 1);
      chk("freeze_count", 32'(count), 1);
    end
    rdy = 1'b1;
    @(negedge clk);
    st_ack = 1'b0;
    chk("resume_st_req", 32'(st_req), 0);
    chk("resume_count", 32'(count), 0);
    // out-of-order writeback
    do_alloc(K_ALU, 5'd7, 2'd2, 32'h60, 1'b0, t);
    do_alloc(K_ALU, 5'd8, 2'd2, 32'h64, 1'b0, t2);
    do_wb(t2, 32'hB2, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("ooo_wait_count", 32'(count), 2);
    chk("ooo_no_commit", 32'(cm_valid), 0);
    cm_q.push_back('{t, 5'd7, 32'hA1});
    cm_q.push_back('{t2, 5'd8, 32'hB2});
    do_wb(t, 32'hA1, 0, 0, 1'b0);
    @(negedge clk);
    chk("ooo_first", {28'd0, cm_valid, cm_tag}, {28'd1, t});
    @(negedge clk);
    chk("ooo_second", {28'd0, cm_valid, cm_tag}, {28'd1, t2});
    @(negedge clk);
    chk("ooo_count", 32'(count), 0);
    // mispredicted taken branch flushes a younger op
    do_alloc(K_BR, 5'd0, 2'd0, 32'h100, 1'b0, t);
    do_alloc(K_ALU, 5'd3, 2'd2, 32'h104, 1'b0, t2);
    bp_q.push_back({32'h100, 1'b1});
    fl_q.push_back(32'h200);
    do_wb(t, 32'h0, 0, 32'h200, 1'b1);
    @(negedge clk);
    chk("flush_high", 32'(flush), 1);
    chk("flush_alloc_ready", 32'(alloc_ready), 0);
    @(negedge clk);
    tl = 0;
    chk("flush_one_cycle", 32'(flush), 0);
    chk("flush_count", 32'(count), 0);
    chk("flush_alloc_tag", 32'(alloc_tag), 1);
    // JALR always redirects
    do_alloc(K_JALR, 5'd1, 2'd2, 32'h300, 1'b0, t);
    cm_q.push_back('{t, 5'd1, 32'h304});
    fl_q.push_back(32'h500);
    do_wb(t, 32'h304, 0, 32'h500, 1'b1);
    repeat (3) @(negedge clk);
    tl = 0;
    chk("jalr_count", 32'(count), 0);
    // correctly predicted branch, then predicted-taken branch that falls through
    do_alloc(K_BR, 5'd0, 2'd0, 32'h600, 1'b0, t);
    bp_q.push_back({32'h600, 1'b0});
    do_wb(t, 32'h0, 0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    do_alloc(K_BR, 5'd0, 2'd0, 32'h400, 1'b1, t);
    bp_q.push_back({32'h400, 1'b0});
    fl_q.push_back(32'h404);
    do_wb(t, 32'h0, 0, 32'h900, 1'b0);
    repeat (3) @(negedge clk);
    tl = 0;
    chk("nt_flush_count", 32'(count), 0);
    // reset during a pending store abandons it
    do_alloc(K_ST, 5'd0, 2'd0, 32'h70, 1'b0, t);
    st_q.push_back('{32'h3000, 32'h99, 2'd0});
    do_wb(t, 32'h99, 32'h3000, 0, 1'b0);
    @(negedge clk);
    chk("pre_rst_st_req", 32'(st_req), 1);
    chk_addr = 32'h3000;
    rst = 1'b0;
    #1;
    chk("rst_st_req", 32'(st_req), 0);
    chk("rst_count_mid", 32'(count), 0);
    chk("rst_chk_hit", 32'(chk_hit), 0);
    @(negedge clk);
    rst = 1'b1;
    tl = 0;
    @(negedge clk);
    chk("post_rst_alloc_tag", 32'(alloc_tag), 1);
    chk("cm_q_drained", 32'(cm_q.size()), 0);
    chk("bp_q_drained", 32'(bp_q.size()), 0);
    chk("fl_q_drained", 32'(fl_q.size()), 0);
    chk("st_q_drained", 32'(st_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
